// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared state encodings and width constants for the MAC stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int PROD_W    = 16;
    localparam int DEF_ACC_W = 24;
    localparam int DEF_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/multiplier_8bits_version0.sv
// ============================================================================
// Module   : multiplier_8bits_version0
// Brief    : Combinational 8x8 unsigned multiplier (16-bit product).
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiplier_8bits_version0 (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_product
);

    logic [15:0] w_pp [8];
    logic [15:0] w_sum;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_pp
        assign w_pp[gi] = {8'b0, (i_a & {8{i_b[gi]}})} << gi;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    assign o_product = w_sum;

endmodule

`default_nettype wire

// File: rtl/mac_accum_8bits.sv
// ============================================================================
// Module   : mac_accum_8bits
// Brief    : Registered operand stage, 8x8 multiplier and wide accumulator
//            presenting each finished sum on a valid/ready output.
//            Optional macro MAC_ACCUM_SATURATE_EN clamps on overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_accum_8bits
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    if (ACC_W < PROD_W || ACC_W > 32) begin : g_acc_w_check
        $error("mac_accum_8bits: ACC_W must lie in 16..32");
    end

    state_t            r_state;
    logic              r_s1_valid;
    logic [7:0]        r_s1_a;
    logic [7:0]        r_s1_b;
    logic              r_s1_last;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_acc;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_ovf;

    state_t            w_state_nxt;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ovf_nxt;
    logic              w_out_valid_nxt;
    logic [ACC_W-1:0]  w_out_acc_nxt;
    logic [CNT_W-1:0]  w_out_count_nxt;
    logic              w_out_ovf_nxt;

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W:0]    w_sum;
    logic              w_term_ovf;
    logic [ACC_W-1:0]  w_val;

    multiplier_8bits_version0 u_mult (
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .o_product (w_prod)
    );

    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, w_prod};
    assign w_term_ovf = r_ovf | w_sum[ACC_W];

`ifdef MAC_ACCUM_SATURATE_EN
    // Once the sum has overflowed it stays pinned at all-ones.
    assign w_val = w_term_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_val = w_sum[ACC_W-1:0];
`endif

    // Depends on registered state only, so no combinational path from inputs.
    assign in_ready = !r_s1_valid || (r_state == ST_ACCUM);

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        w_out_acc_nxt   = r_out_acc;
        w_out_count_nxt = r_out_count;
        w_out_ovf_nxt   = r_out_ovf;
        case (r_state)
            ST_ACCUM: begin
                if (r_s1_valid) begin
                    if (!r_s1_last) begin
                        w_acc_nxt = w_val;
                        w_cnt_nxt = r_cnt + c_cnt_one;
                        w_ovf_nxt = w_term_ovf;
                    end else begin
                        w_out_acc_nxt   = w_val;
                        w_out_count_nxt = r_cnt + c_cnt_one;
                        w_out_ovf_nxt   = w_term_ovf;
                        w_out_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_ovf_nxt       = 1'b0;
                        w_state_nxt     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_acc   <= w_out_acc_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
        end
    end

    // S1 refills whenever it can accept; in ACCUM the old term is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_last  <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_last <= in_last;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_accum_8bits.sv
// ============================================================================
// Module   : tb_mac_accum_8bits
// Brief    : Directed bench for mac_accum_8bits (default, ACC_W=16, CNT_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mac_accum_8bits;

`ifdef MAC_ACCUM_SATURATE_EN
    localparam int c_exp_acc16 = 65535;
`else
    localparam int c_exp_acc16 = 64514;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  rdy16,  rdyc2;
    logic        out_valid, ov16,   ovc2;
    logic [23:0] out_acc;
    logic [15:0] acc16;
    logic [23:0] accc2;
    logic [7:0]  out_count, cnt16;
    logic [1:0]  cntc2;
    logic        out_ovf,   ovf16,  ovfc2;

    int n_checks = 0;
    int n_errors = 0;

    mac_accum_8bits dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    mac_accum_8bits #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov16),
        .out_ready(out_ready), .out_acc(acc16), .out_count(cnt16), .out_ovf(ovf16)
    );

    mac_accum_8bits #(.ACC_W(24), .CNT_W(2)) dutc2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyc2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ovc2),
        .out_ready(out_ready), .out_acc(accc2), .out_count(cntc2), .out_ovf(ovfc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one term and return #1 after the edge that transferred it.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_accept", {31'b0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_acc",   {8'b0, out_acc}, 0);
        chk("rst_out_count", {24'b0, out_count}, 0);
        chk("rst_out_ovf",   {31'b0, out_ovf}, 0);
        chk("rst_in_ready",  {31'b0, in_ready}, 1);
        rst = 1'b0;
        tick();

        // Single term 255*255, exact latency
        send(8'd255, 8'd255, 1'b1);
        chk("single_early", {31'b0, out_valid}, 0);
        tick();
        chk("single_valid", {31'b0, out_valid}, 1);
        chk("single_acc",   {8'b0, out_acc}, 65025);
        chk("single_count", {24'b0, out_count}, 1);
        chk("single_ovf",   {31'b0, out_ovf}, 0);
        tick();
        chk("single_release", {31'b0, out_valid}, 0);

        // Back-to-back stream 3*4 + 5*6 + 7*8
        chk("stream_rdy0", {31'b0, in_ready}, 1);
        send(8'd3, 8'd4, 1'b0);
        chk("stream_rdy1", {31'b0, in_ready}, 1);
        send(8'd5, 8'd6, 1'b0);
        chk("stream_rdy2", {31'b0, in_ready}, 1);
        send(8'd7, 8'd8, 1'b1);
        tick();
        chk("stream_valid", {31'b0, out_valid}, 1);
        chk("stream_acc",   {8'b0, out_acc}, 98);
        chk("stream_count", {24'b0, out_count}, 3);
        tick();

        // Backpressure: result held while new terms queue up
        out_ready = 1'b0;
        send(8'd1, 8'd1, 1'b1);
        tick();
        chk("hold_valid", {31'b0, out_valid}, 1);
        send(8'd2, 8'd2, 1'b0);
        chk("hold_s1_full", {31'b0, in_ready}, 0);
        in_a = 8'd3; in_b = 8'd3; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_stable_valid", {31'b0, out_valid}, 1);
            chk("hold_stable_acc",   {8'b0, out_acc}, 1);
            chk("hold_stable_count", {24'b0, out_count}, 1);
            chk("hold_ready_low",    {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("hold_drop", {31'b0, out_valid}, 0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("hold_next_valid", {31'b0, out_valid}, 1);
        chk("hold_next_acc",   {8'b0, out_acc}, 13);
        chk("hold_next_count", {24'b0, out_count}, 2);
        tick();

        // Zero-product terms still count
        send(8'd0, 8'd7, 1'b0);
        send(8'd0, 8'd0, 1'b1);
        tick();
        chk("zero_acc",   {8'b0, out_acc}, 0);
        chk("zero_count", {24'b0, out_count}, 2);
        tick();

        // Overflow on a 16-bit accumulator
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        tick();
        chk("ovf16_valid", {31'b0, ov16}, 1);
        chk("ovf16_acc",   {16'b0, acc16}, c_exp_acc16);
        chk("ovf16_flag",  {31'b0, ovf16}, 1);
        chk("ovf24_acc",   {8'b0, out_acc}, 130050);
        chk("ovf24_flag",  {31'b0, out_ovf}, 0);
        tick();

        // Asynchronous reset mid-sum
        send(8'd10, 8'd10, 1'b0);
        send(8'd20, 8'd20, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 0);
        chk("midrst_acc",   {8'b0, out_acc}, 0);
        chk("midrst_ready", {31'b0, in_ready}, 1);
        tick();
        rst = 1'b0;
        send(8'd2, 8'd3, 1'b1);
        tick();
        chk("postrst_acc",   {8'b0, out_acc}, 6);
        chk("postrst_count", {24'b0, out_count}, 1);
        chk("postrst_ovf",   {31'b0, out_ovf}, 0);
        tick();

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        send(8'd9, 8'd9, 1'b1);
        tick();
        chk("holdrst_pre_acc", {8'b0, out_acc}, 81);
        #2 rst = 1'b1;
        #1;
        chk("holdrst_valid", {31'b0, out_valid}, 0);
        chk("holdrst_acc",   {8'b0, out_acc}, 0);
        chk("holdrst_count", {24'b0, out_count}, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Counter wrap with CNT_W=2
        for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        tick();
        chk("wrap_valid",   {31'b0, ovc2}, 1);
        chk("wrap_acc",     {8'b0, accc2}, 5);
        chk("wrap_count",   {30'b0, cntc2}, 1);
        chk("wrap_count8",  {24'b0, out_count}, 5);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
